// File: rtl/clk_divider_multi.sv
// clk_divider_multi: multi-channel 50% duty clock divider with glitch-free runtime half-period reload and global sync.
module clk_divider_multi #(
  parameter int NUM_CH       = 4,
  parameter int CTR_W        = 27,
  parameter int CH_W         = 2,
  parameter int DEFAULT_HALF = 50_000
) (
  input  logic              incoming_CLK100MHZ,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              load_valid,
  input  logic [CH_W-1:0]   load_ch,
  input  logic [CTR_W-1:0]  load_half,
  output logic [NUM_CH-1:0] outgoing_CLK,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending,
  output logic              load_err
);
  logic load_ok, load_err_q;
  assign load_ok  = load_valid && int'(load_ch) < NUM_CH && load_half != '0;
  assign load_err = load_err_q;
  always_ff @(posedge incoming_CLK100MHZ) begin
    load_err_q <= !reset && load_valid && !load_ok;
  end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CTR_W-1:0] ctr_q, ctr_d, act_q, act_d, nxt_q, nxt_d;
    logic pend_q, pend_d, out_q, out_d, tick_q, tick_d, run, hit, apply, wr;
    // pending value lands only on a falling edge (period boundary), sync or disable
    always_comb begin
      run    = en[c] && !sync;
      hit    = ctr_q == act_q - CTR_W'(1);
      apply  = pend_q && (!run || (hit && out_q));
      wr     = load_ok && load_ch == CH_W'(c);
      ctr_d  = run && !hit ? ctr_q + CTR_W'(1) : '0;
      out_d  = run && (out_q ^ hit);
      tick_d = run && hit && !out_q;
      act_d  = apply ? nxt_q : act_q;
      nxt_d  = wr ? load_half : nxt_q;
      pend_d = wr || (pend_q && !apply);
    end
    always_ff @(posedge incoming_CLK100MHZ) begin
      if (reset) begin
        ctr_q  <= '0;
        act_q  <= CTR_W'(DEFAULT_HALF);
        nxt_q  <= '0;
        pend_q <= 1'b0;
        out_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        ctr_q  <= ctr_d;
        act_q  <= act_d;
        nxt_q  <= nxt_d;
        pend_q <= pend_d;
        out_q  <= out_d;
        tick_q <= tick_d;
      end
    end
    assign outgoing_CLK[c] = out_q;
    assign tick[c]         = tick_q;
    assign pending[c]      = pend_q;
  end
endmodule
